// File: rtl/store_buffer_if.sv
// Store buffer package (sizing) and port bundle between dispatch/execute/ROB/memory and the buffer.
// Optional load forwarding ports are present only when SB_FWD_EN is defined.
package store_buffer_pkg;
  localparam int unsigned SB_ENTRY = 8;
  localparam int unsigned ADDR_W   = 16;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned SB_IDX_W = $clog2(SB_ENTRY);
  localparam int unsigned SB_PTR_W = SB_IDX_W + 1;
endpackage

interface store_buffer_if;
  import store_buffer_pkg::*;

  logic                alloc_v_i;
  logic                alloc_ready_o;
  logic [SB_IDX_W-1:0] alloc_sb_num_o;
  logic                exe_v_i;
  logic [SB_IDX_W-1:0] exe_sb_num_i;
  logic [ADDR_W-1:0]   exe_addr_i;
  logic [DATA_W-1:0]   exe_data_i;
  logic                commit_v_i;
  logic                flush_i;
  logic                mem_v_o;
  logic [ADDR_W-1:0]   mem_addr_o;
  logic [DATA_W-1:0]   mem_data_o;
  logic                mem_ready_i;
  logic [SB_ENTRY-1:0] sb_wb_vector_o;
  logic [SB_IDX_W-1:0] sb_commit_pt_o;
`ifdef SB_FWD_EN
  logic                ld_v_i;
  logic [ADDR_W-1:0]   ld_addr_i;
  logic [SB_IDX_W-1:0] ld_sb_num_i;
  logic                fwd_hit_o;
  logic [DATA_W-1:0]   fwd_data_o;
`endif

  modport master (
    output alloc_v_i, exe_v_i, exe_sb_num_i, exe_addr_i, exe_data_i,
           commit_v_i, flush_i, mem_ready_i,
    input  alloc_ready_o, alloc_sb_num_o, mem_v_o, mem_addr_o, mem_data_o,
           sb_wb_vector_o, sb_commit_pt_o
`ifdef SB_FWD_EN
    , output ld_v_i, ld_addr_i, ld_sb_num_i
    , input  fwd_hit_o, fwd_data_o
`endif
  );

  modport slave (
    input  alloc_v_i, exe_v_i, exe_sb_num_i, exe_addr_i, exe_data_i,
           commit_v_i, flush_i, mem_ready_i,
    output alloc_ready_o, alloc_sb_num_o, mem_v_o, mem_addr_o, mem_data_o,
           sb_wb_vector_o, sb_commit_pt_o
`ifdef SB_FWD_EN
    , input  ld_v_i, ld_addr_i, ld_sb_num_i
    , output fwd_hit_o, fwd_data_o
`endif
  );
endinterface

// File: rtl/store_buffer.sv
// In-order circular store queue: allocate at dispatch, fill at execute, commit from ROB, drain oldest-first.
// Define SB_FWD_EN to add store-to-load forwarding search.
module store_buffer
  import store_buffer_pkg::*;
(
  input logic           clk_i,
  input logic           rst_n_i,
  store_buffer_if.slave sb
);

  logic [SB_PTR_W-1:0] r_head, r_cmt, r_tail;
  logic [SB_ENTRY-1:0] r_valid, r_wb;
  logic [ADDR_W-1:0]   r_addr [SB_ENTRY];
  logic [DATA_W-1:0]   r_data [SB_ENTRY];

  logic                w_full, w_mem_v, w_alloc, w_drain, w_commit, w_exe_ok;
  logic [SB_PTR_W-1:0] w_cmt_n, w_head_n, w_tail_n, w_sq_cnt;
  logic [SB_IDX_W-1:0] w_head_idx, w_tail_idx, w_exe_idx;
  logic [SB_ENTRY-1:0] w_squash, w_alloc_mask, w_drain_mask, w_exe_mask;

  assign w_head_idx = r_head[SB_IDX_W-1:0];
  assign w_tail_idx = r_tail[SB_IDX_W-1:0];
  assign w_exe_idx  = sb.exe_sb_num_i;

  assign w_full   = (r_head[SB_IDX_W] != r_tail[SB_IDX_W]) && (w_head_idx == w_tail_idx);
  assign w_mem_v  = (r_head != r_cmt) && r_wb[w_head_idx];
  assign w_alloc  = sb.alloc_v_i && !w_full && !sb.flush_i;
  assign w_drain  = w_mem_v && sb.mem_ready_i;
  assign w_commit = sb.commit_v_i && (r_cmt != r_tail);

  assign w_cmt_n  = r_cmt + SB_PTR_W'(w_commit);
  assign w_head_n = r_head + SB_PTR_W'(w_drain);
  assign w_tail_n = sb.flush_i ? w_cmt_n : (r_tail + SB_PTR_W'(w_alloc));
  assign w_sq_cnt = r_tail - w_cmt_n;

  // Flush squashes every entry in [cmt_next, tail), i.e. whatever stays uncommitted after this cycle
  always_comb begin
    w_squash = '0;
    for (int i = 0; i < SB_ENTRY; i++) begin
      if (sb.flush_i &&
          ({1'b0, SB_IDX_W'(SB_IDX_W'(i) - w_cmt_n[SB_IDX_W-1:0])} < w_sq_cnt))
        w_squash[i] = 1'b1;
    end
  end

  assign w_exe_ok = sb.exe_v_i && r_valid[w_exe_idx] && !w_squash[w_exe_idx] &&
                    !(w_drain && (w_exe_idx == w_head_idx));

  always_comb begin
    w_alloc_mask = '0;
    w_drain_mask = '0;
    w_exe_mask   = '0;
    if (w_alloc)  w_alloc_mask[w_tail_idx] = 1'b1;
    if (w_drain)  w_drain_mask[w_head_idx] = 1'b1;
    if (w_exe_ok) w_exe_mask[w_exe_idx]    = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_head  <= '0;
      r_cmt   <= '0;
      r_tail  <= '0;
      r_valid <= '0;
      r_wb    <= '0;
      for (int i = 0; i < SB_ENTRY; i++) begin
        r_addr[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      r_head  <= w_head_n;
      r_cmt   <= w_cmt_n;
      r_tail  <= w_tail_n;
      r_valid <= (r_valid & ~w_squash & ~w_drain_mask) | w_alloc_mask;
      r_wb    <= (r_wb & ~w_alloc_mask) | w_exe_mask;
      if (w_exe_ok) begin
        r_addr[w_exe_idx] <= sb.exe_addr_i;
        r_data[w_exe_idx] <= sb.exe_data_i;
      end
    end
  end

  assign sb.alloc_ready_o  = !w_full;
  assign sb.alloc_sb_num_o = w_tail_idx;
  assign sb.mem_v_o        = w_mem_v;
  assign sb.mem_addr_o     = r_addr[w_head_idx];
  assign sb.mem_data_o     = r_data[w_head_idx];
  assign sb.sb_wb_vector_o = r_wb;
  assign sb.sb_commit_pt_o = w_head_idx;

`ifdef SB_FWD_EN
  logic [SB_IDX_W-1:0] w_ld_dist;
  assign w_ld_dist = sb.ld_sb_num_i - w_head_idx;

  // Walk oldest to youngest so the last match (youngest) wins
  always_comb begin
    sb.fwd_hit_o  = 1'b0;
    sb.fwd_data_o = '0;
    for (int k = 0; k < SB_ENTRY; k++) begin
      if (sb.ld_v_i && (SB_IDX_W'(k) <= w_ld_dist) &&
          r_valid[SB_IDX_W'(w_head_idx + SB_IDX_W'(k))] &&
          r_wb[SB_IDX_W'(w_head_idx + SB_IDX_W'(k))] &&
          (r_addr[SB_IDX_W'(w_head_idx + SB_IDX_W'(k))] == sb.ld_addr_i)) begin
        sb.fwd_hit_o  = 1'b1;
        sb.fwd_data_o = r_data[SB_IDX_W'(w_head_idx + SB_IDX_W'(k))];
      end
    end
  end
`endif

  a_commit_legal: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    !(sb.commit_v_i && (r_cmt == r_tail)));

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer with hand-computed expectations.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if u_if ();

  store_buffer u_dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .sb      (u_if)
  );

  int n_errors = 0;
  int n_checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.alloc_v_i    = 1'b0;
    u_if.exe_v_i      = 1'b0;
    u_if.exe_sb_num_i = '0;
    u_if.exe_addr_i   = '0;
    u_if.exe_data_i   = '0;
    u_if.commit_v_i   = 1'b0;
    u_if.flush_i      = 1'b0;
    u_if.mem_ready_i  = 1'b0;
`ifdef SB_FWD_EN
    u_if.ld_v_i       = 1'b0;
    u_if.ld_addr_i    = '0;
    u_if.ld_sb_num_i  = '0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic exe(input int num, input logic [15:0] addr, input logic [15:0] data);
    u_if.exe_v_i      = 1'b1;
    u_if.exe_sb_num_i = SB_IDX_W'(num);
    u_if.exe_addr_i   = addr;
    u_if.exe_data_i   = data;
    step();
    u_if.exe_v_i      = 1'b0;
  endtask

  task automatic alloc_n(input int n);
    u_if.alloc_v_i = 1'b1;
    repeat (n) step();
    u_if.alloc_v_i = 1'b0;
  endtask

  task automatic commit_n(input int n);
    u_if.commit_v_i = 1'b1;
    repeat (n) step();
    u_if.commit_v_i = 1'b0;
  endtask

  initial begin
    idle_inputs();
    step();
    // Reset values while reset is held
    check("rst_ready",  32'(u_if.alloc_ready_o),  1);
    check("rst_num",    32'(u_if.alloc_sb_num_o), 0);
    check("rst_mem_v",  32'(u_if.mem_v_o),        0);
    check("rst_addr",   32'(u_if.mem_addr_o),     0);
    check("rst_data",   32'(u_if.mem_data_o),     0);
    check("rst_wbvec",  32'(u_if.sb_wb_vector_o), 0);
    check("rst_cpt",    32'(u_if.sb_commit_pt_o), 0);
    rst_n = 1'b1;
    step();

    // Fill all 8 entries back to back, 9th request refused
    u_if.alloc_v_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("fill_num", 32'(u_if.alloc_sb_num_o), 32'(i));
      check("fill_rdy", 32'(u_if.alloc_ready_o), 1);
      step();
    end
    check("full_rdy", 32'(u_if.alloc_ready_o), 0);
    step();
    check("ninth_rdy", 32'(u_if.alloc_ready_o), 0);
    check("ninth_num", 32'(u_if.alloc_sb_num_o), 0);
    u_if.alloc_v_i = 1'b0;
    do_reset();
    check("midrst_rdy", 32'(u_if.alloc_ready_o), 1);
    check("midrst_num", 32'(u_if.alloc_sb_num_o), 0);

    // Out-of-order execute; drain waits for committed, written head
    alloc_n(3);
    exe(2, 16'h0040, 16'hBEEF);
    check("wb_e2", 32'(u_if.sb_wb_vector_o), 32'h04);
    check("memv_e2", 32'(u_if.mem_v_o), 0);
    commit_n(3);
    check("memv_nowb", 32'(u_if.mem_v_o), 0);
    exe(0, 16'h0010, 16'h0A0A);
    check("memv_h0", 32'(u_if.mem_v_o), 1);
    check("addr_h0", 32'(u_if.mem_addr_o), 32'h0010);
    check("data_h0", 32'(u_if.mem_data_o), 32'h0A0A);
    exe(1, 16'h0020, 16'h1234);
    check("wb_012", 32'(u_if.sb_wb_vector_o), 32'h07);
    step();
    check("hold_memv", 32'(u_if.mem_v_o), 1);
    check("hold_cpt", 32'(u_if.sb_commit_pt_o), 0);
    u_if.mem_ready_i = 1'b1;
    step();
    check("drain_cpt1", 32'(u_if.sb_commit_pt_o), 1);
    check("drain_addr1", 32'(u_if.mem_addr_o), 32'h0020);
    step();
    check("drain_cpt2", 32'(u_if.sb_commit_pt_o), 2);
    check("drain_data2", 32'(u_if.mem_data_o), 32'hBEEF);
    step();
    check("drain_cpt3", 32'(u_if.sb_commit_pt_o), 3);
    check("drain_memv3", 32'(u_if.mem_v_o), 0);
    u_if.mem_ready_i = 1'b0;

    // Flush with 5 allocated, 2 committed; same-cycle alloc dropped
    do_reset();
    alloc_n(5);
    exe(0, 16'h0100, 16'hAAAA);
    exe(1, 16'h0102, 16'hBBBB);
    commit_n(2);
    u_if.flush_i   = 1'b1;
    u_if.alloc_v_i = 1'b1;
    step();
    u_if.flush_i   = 1'b0;
    check("flush_num", 32'(u_if.alloc_sb_num_o), 2);
    check("flush_rdy", 32'(u_if.alloc_ready_o), 1);
    step();
    u_if.alloc_v_i = 1'b0;
    check("realloc_num", 32'(u_if.alloc_sb_num_o), 3);
    exe(4, 16'h0104, 16'hDDDD);
    check("sq_exe_wb", 32'(u_if.sb_wb_vector_o), 32'h03);
    check("flush_memv", 32'(u_if.mem_v_o), 1);
    check("flush_addr", 32'(u_if.mem_addr_o), 32'h0100);
    u_if.mem_ready_i = 1'b1;
    step();
    check("fdrain_cpt1", 32'(u_if.sb_commit_pt_o), 1);
    check("fdrain_data1", 32'(u_if.mem_data_o), 32'hBBBB);
    step();
    check("fdrain_cpt2", 32'(u_if.sb_commit_pt_o), 2);
    check("fdrain_memv", 32'(u_if.mem_v_o), 0);
    u_if.mem_ready_i = 1'b0;

    // Full buffer: drain and alloc same cycle -> refused, then wraps to index 0
    do_reset();
    alloc_n(8);
    exe(0, 16'h0200, 16'hCCCC);
    commit_n(1);
    check("wrap_memv", 32'(u_if.mem_v_o), 1);
    check("wrap_full", 32'(u_if.alloc_ready_o), 0);
    u_if.mem_ready_i = 1'b1;
    u_if.alloc_v_i   = 1'b1;
    step();
    u_if.mem_ready_i = 1'b0;
    check("wrap_rdy", 32'(u_if.alloc_ready_o), 1);
    check("wrap_cpt", 32'(u_if.sb_commit_pt_o), 1);
    check("wrap_num0", 32'(u_if.alloc_sb_num_o), 0);
    step();
    u_if.alloc_v_i = 1'b0;
    check("wrap_num1", 32'(u_if.alloc_sb_num_o), 1);
    check("wrap_full2", 32'(u_if.alloc_ready_o), 0);

`ifdef SB_FWD_EN
    // Forwarding: youngest matching store at or older than ld_sb_num_i
    do_reset();
    alloc_n(4);
    exe(0, 16'h0080, 16'h1111);
    exe(1, 16'h0090, 16'h5555);
    exe(3, 16'h0080, 16'h2222);
    u_if.ld_v_i      = 1'b1;
    u_if.ld_addr_i   = 16'h0080;
    u_if.ld_sb_num_i = 3'd3;
    #1;
    check("fwd_hit3", 32'(u_if.fwd_hit_o), 1);
    check("fwd_data3", 32'(u_if.fwd_data_o), 32'h2222);
    u_if.ld_sb_num_i = 3'd2;
    #1;
    check("fwd_hit2", 32'(u_if.fwd_hit_o), 1);
    check("fwd_data2", 32'(u_if.fwd_data_o), 32'h1111);
    u_if.ld_addr_i = 16'h00A0;
    #1;
    check("fwd_miss", 32'(u_if.fwd_hit_o), 0);
    u_if.ld_addr_i = 16'h0080;
    u_if.ld_v_i    = 1'b0;
    #1;
    check("fwd_nold", 32'(u_if.fwd_hit_o), 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
